// File: rtl/cfg_width_update_ctrl.sv
// cfg_width_update_ctrl: range-checks runtime width change requests, drains the
// downstream datapath, then commits the new width and reports a 2-bit result.
module cfg_width_update_ctrl #(
    parameter int WIDTH_W       = 7,
    parameter int MIN_WIDTH     = 8,
    parameter int MAX_WIDTH     = 64,
    parameter int DEFAULT_WIDTH = 32,
    parameter int TIMEOUT       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH_W-1:0] req_width,
    input  logic               datapath_idle,
    output logic               cfg_stall,
    output logic               cfg_update,
    output logic [WIDTH_W-1:0] active_width,
    output logic [1:0]         status,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [1:0]         resp_result
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [1:0] SUCCESS = 2'b00, FAILURE = 2'b01, PENDING = 2'b10, ERROR_CODE = 2'b11;

    typedef enum logic [2:0] {IDLE, CHECK, DRAIN, APPLY, RESP} state_t;

    state_t             state, next;
    logic [WIDTH_W-1:0] req_q;
    logic [CNT_W-1:0]   cnt;
    logic               in_range, drain_last;

    assign in_range   = req_q >= WIDTH_W'(MIN_WIDTH) && req_q <= WIDTH_W'(MAX_WIDTH);
    assign drain_last = cnt == CNT_W'(TIMEOUT - 1);

    always_comb begin
        next        = state;
        req_ready   = state == IDLE;
        cfg_stall   = state == DRAIN || state == APPLY;
        cfg_update  = state == APPLY;
        resp_valid  = state == RESP;
        status      = (state == CHECK || state == DRAIN || state == APPLY) ? PENDING : resp_result;
        case (state)
            IDLE:    next = req_valid ? CHECK : IDLE;
            CHECK:   next = in_range ? DRAIN : RESP;
            DRAIN:   next = datapath_idle ? APPLY : (drain_last ? RESP : DRAIN);
            APPLY:   next = RESP;
            RESP:    next = resp_ready ? IDLE : RESP;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_q        <= '0;
            cnt          <= '0;
            active_width <= WIDTH_W'(DEFAULT_WIDTH);
            resp_result  <= SUCCESS;
        end else begin
            state <= next;
            cnt   <= state == DRAIN ? cnt + 1'b1 : '0;
            if (state == IDLE && req_valid)
                req_q <= req_width;
            if (state == CHECK && !in_range)
                resp_result <= FAILURE;
            // idle takes priority over the timeout in the same cycle
            if (state == DRAIN && !datapath_idle && drain_last)
                resp_result <= ERROR_CODE;
            if (state == APPLY) begin
                active_width <= req_q;
                resp_result  <= SUCCESS;
            end
        end
    end
endmodule

// File: tb/tb_cfg_width_update_ctrl.sv
// tb_cfg_width_update_ctrl: directed scenarios for the width update controller.
module tb_cfg_width_update_ctrl;
    logic       clk = 0, rst_n = 0, req_valid = 0, datapath_idle = 1, resp_ready = 0;
    logic [6:0] req_width = '0;
    logic       req_ready, cfg_stall, cfg_update, resp_valid;
    logic [6:0] active_width;
    logic [1:0] status, resp_result;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    cfg_width_update_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_width(req_width), .datapath_idle(datapath_idle), .cfg_stall(cfg_stall),
        .cfg_update(cfg_update), .active_width(active_width), .status(status),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [6:0] w);
        req_width = w;
        req_valid = 1;
        step();
        req_valid = 0;
    endtask

    task automatic handshake();
        resp_ready = 1;
        step();
        resp_ready = 0;
    endtask

    task automatic test_reset();
        step();
        checks++; if (active_width !== 7'd32) begin errors++; $display("FAIL reset_active got=%0d exp=32", active_width); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (status !== 2'b00) begin errors++; $display("FAIL reset_status got=%b exp=00", status); end
        checks++; if ({cfg_stall, cfg_update} !== 2'b00) begin errors++; $display("FAIL reset_stall_update got=%b exp=00", {cfg_stall, cfg_update}); end
        rst_n = 1;
        step();
    endtask

    task automatic test_basic();
        accept(7'd16);
        checks++; if (status !== 2'b10 || req_ready !== 1'b0) begin errors++; $display("FAIL basic_check status=%b req_ready=%b exp 10/0", status, req_ready); end
        step();
        checks++; if ({cfg_stall, cfg_update} !== 2'b10) begin errors++; $display("FAIL basic_drain stall_update=%b exp=10", {cfg_stall, cfg_update}); end
        step();
        checks++; if ({cfg_stall, cfg_update} !== 2'b11 || active_width !== 7'd32) begin errors++; $display("FAIL basic_apply stall_update=%b active=%0d exp 11/32", {cfg_stall, cfg_update}, active_width); end
        step();
        checks++; if (resp_valid !== 1'b1 || active_width !== 7'd16 || resp_result !== 2'b00) begin errors++; $display("FAIL basic_resp valid=%b active=%0d result=%b exp 1/16/00", resp_valid, active_width, resp_result); end
        checks++; if (cfg_update !== 1'b0 || status !== 2'b00) begin errors++; $display("FAIL basic_after update=%b status=%b exp 0/00", cfg_update, status); end
        handshake();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL basic_idle req_ready=%b resp_valid=%b exp 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_same_width();
        accept(7'd16);
        step();
        step();
        checks++; if (cfg_update !== 1'b1) begin errors++; $display("FAIL same_update got=%b exp=1", cfg_update); end
        step();
        checks++; if (resp_result !== 2'b00 || active_width !== 7'd16) begin errors++; $display("FAIL same_resp result=%b active=%0d exp 00/16", resp_result, active_width); end
        handshake();
    endtask

    task automatic test_boundaries();
        logic [6:0] w[4]   = '{7'd8, 7'd64, 7'd7, 7'd65};
        logic [1:0] res[4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        for (int i = 0; i < 4; i++) begin
            int  n = 0;
            logic seen = 0;
            accept(w[i]);
            while (!resp_valid && n < 10) begin
                seen |= cfg_stall | cfg_update;
                step();
                n++;
            end
            checks++; if (resp_valid !== 1'b1 || resp_result !== res[i]) begin errors++; $display("FAIL bound_result w=%0d valid=%b got=%b exp=%b", w[i], resp_valid, resp_result, res[i]); end
            checks++; if (seen !== (res[i] == 2'b00)) begin errors++; $display("FAIL bound_stall w=%0d got=%b exp=%b", w[i], seen, res[i] == 2'b00); end
            if (res[i] == 2'b00) begin
                checks++; if (n !== 3) begin errors++; $display("FAIL bound_latency w=%0d got=%0d exp=3", w[i], n); end
            end else begin
                checks++; if (n > 2) begin errors++; $display("FAIL bound_latency w=%0d got=%0d exp<=2", w[i], n); end
            end
            handshake();
        end
        checks++; if (active_width !== 7'd64) begin errors++; $display("FAIL bound_final got=%0d exp=64", active_width); end
    endtask

    task automatic test_timeout();
        int n = 0;
        datapath_idle = 0;
        accept(7'd40);
        for (int i = 0; i < 30 && !resp_valid; i++) begin
            if (cfg_stall) n++;
            step();
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL timeout_stall_cycles got=%0d exp=16", n); end
        checks++; if (resp_valid !== 1'b1 || resp_result !== 2'b11 || status !== 2'b11) begin errors++; $display("FAIL timeout_result valid=%b result=%b status=%b exp 1/11/11", resp_valid, resp_result, status); end
        checks++; if (active_width !== 7'd64 || cfg_stall !== 1'b0) begin errors++; $display("FAIL timeout_active active=%0d stall=%b exp 64/0", active_width, cfg_stall); end
        handshake();
    endtask

    task automatic test_idle_late();
        datapath_idle = 0;
        accept(7'd24);
        step();
        repeat (15) step();
        checks++; if (cfg_stall !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL late_drain stall=%b valid=%b exp 1/0", cfg_stall, resp_valid); end
        datapath_idle = 1;
        step();
        checks++; if (cfg_update !== 1'b1) begin errors++; $display("FAIL late_apply update=%b exp=1", cfg_update); end
        step();
        checks++; if (resp_result !== 2'b00 || active_width !== 7'd24) begin errors++; $display("FAIL late_resp result=%b active=%0d exp 00/24", resp_result, active_width); end
        handshake();
    endtask

    task automatic test_back_to_back();
        accept(7'd20);
        repeat (3) step();
        req_width = 7'd48;
        req_valid = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (resp_valid !== 1'b1 || resp_result !== 2'b00 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold cyc=%0d valid=%b result=%b req_ready=%b exp 1/00/0", i, resp_valid, resp_result, req_ready); end
        end
        resp_ready = 1;
        step();
        resp_ready = 0;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || active_width !== 7'd20) begin errors++; $display("FAIL bp_release req_ready=%b valid=%b active=%0d exp 1/0/20", req_ready, resp_valid, active_width); end
        step();
        req_valid = 0;
        checks++; if (status !== 2'b10 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept status=%b req_ready=%b exp 10/0", status, req_ready); end
        repeat (3) step();
        checks++; if (resp_valid !== 1'b1 || active_width !== 7'd48) begin errors++; $display("FAIL bp_second_resp valid=%b active=%0d exp 1/48", resp_valid, active_width); end
        handshake();
    endtask

    task automatic test_mid_reset();
        logic seen = 0;
        datapath_idle = 0;
        accept(7'd10);
        repeat (3) step();
        checks++; if (cfg_stall !== 1'b1) begin errors++; $display("FAIL mrst_drain stall=%b exp=1", cfg_stall); end
        #1 rst_n = 0;
        #1;
        checks++; if (cfg_stall !== 1'b0 || req_ready !== 1'b1 || active_width !== 7'd32 || status !== 2'b00) begin errors++; $display("FAIL mrst_async stall=%b req_ready=%b active=%0d status=%b exp 0/1/32/00", cfg_stall, req_ready, active_width, status); end
        step();
        rst_n = 1;
        datapath_idle = 1;
        repeat (5) begin
            step();
            seen |= resp_valid;
        end
        checks++; if (seen !== 1'b0 || active_width !== 7'd32) begin errors++; $display("FAIL mrst_after resp_seen=%b active=%0d exp 0/32", seen, active_width); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_width();
        test_boundaries();
        test_timeout();
        test_idle_late();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
